ifetch_queue: RTL and testbench

Instruction-fetch front end that owns the program counter, issues word fetches to instruction memory over a request/response handshake with variable latency, and buffers returned words in a small in-order queue. It drives the IF/ID pipeline register directly and sits immediately upstream of the ID stage. Branch and jump redirects and ID-stage stalls enter from the controller. It replaces the single-cycle combinational fetch with one that tolerates multi-cycle memory.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 48 ++++
 rtl/ifetch_queue.sv | 117 +++++++++++
 tb/tb_ifetch_queue.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared fetch-path constants and the queue entry type
package pipe_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

    typedef struct packed {
        logic [INSTR_W-1:0] ir;
        logic [ADDR_W-1:0]  pc4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - in-order buffer of fetched words; flush beats a same-cycle push
module fetch_fifo
    import pipe_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           push_i,
    input  fetch_entry_t                   push_data_i,
    input  logic                           pop_i,
    input  logic                           flush_i,
    output fetch_entry_t                   head_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    fetch_entry_t   mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clock) begin
        if (reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clock) begin
        if (!reset && !flush_i && push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - PC owner, credit-limited fetch issue, response drop and IF/ID register
module ifetch_queue
    import pipe_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ack,
    input  logic                imem_rvalid,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic                ifid_valid,
    output logic [INSTR_W-1:0]  ifid_ir,
    output logic [ADDR_W-1:0]   ifid_pc4
);

    localparam int CW = $clog2(DEPTH+1);

    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  resp_pc_q, resp_pc_d;
    logic [CW-1:0]      outst_q, outst_d;
    logic [CW-1:0]      drop_q, drop_d;
    logic               ifid_valid_q, ifid_valid_d;
    logic [INSTR_W-1:0] ifid_ir_q, ifid_ir_d;
    logic [ADDR_W-1:0]  ifid_pc4_q, ifid_pc4_d;

    logic [CW-1:0]      cnt;
    logic [CW:0]        inflight;
    logic               redirect_go, accept, rsp_keep, pop;
    logic [ADDR_W-1:0]  target_pc;
    fetch_entry_t       head, push_entry;

    // A redirect only counts when ID is not holding the pipeline.
    assign redirect_go = redirect & ~stall;
    assign target_pc   = redirect_pc & ~ADDR_W'(3);
    assign inflight    = {1'b0, outst_q} + {1'b0, cnt};
    assign imem_req    = ~reset & ~redirect_go & (inflight < (CW+1)'(DEPTH));
    assign imem_addr   = fetch_pc_q;
    assign accept      = imem_req & imem_ack;
    assign rsp_keep    = imem_rvalid & (drop_q == '0);
    assign pop         = ~stall & ~redirect & (cnt != '0);
    assign push_entry  = '{ir: imem_rdata, pc4: resp_pc_q + ADDR_W'(4)};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (rsp_keep),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (redirect_go),
        .head_o      (head),
        .count_o     (cnt)
    );

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        resp_pc_d    = resp_pc_q;
        outst_d      = outst_q + CW'(accept) - CW'(imem_rvalid);
        drop_d       = drop_q;
        ifid_valid_d = ifid_valid_q;
        ifid_ir_d    = ifid_ir_q;
        ifid_pc4_d   = ifid_pc4_q;

        if (accept)                         fetch_pc_d = fetch_pc_q + ADDR_W'(4);
        if (rsp_keep)                       resp_pc_d  = resp_pc_q + ADDR_W'(4);
        if (imem_rvalid && drop_q != '0)    drop_d     = drop_q - 1'b1;

        // Every response still owed after this cycle belongs to the old path.
        if (redirect_go) begin
            fetch_pc_d = target_pc;
            resp_pc_d  = target_pc;
            drop_d     = outst_q - CW'(imem_rvalid);
        end

        if (!stall) begin
            if (pop) begin
                ifid_valid_d = 1'b1;
                ifid_ir_d    = head.ir;
                ifid_pc4_d   = head.pc4;
            end else begin
                ifid_valid_d = 1'b0;
                ifid_ir_d    = NOP_INSTR;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q   <= RESET_PC;
            resp_pc_q    <= RESET_PC;
            outst_q      <= '0;
            drop_q       <= '0;
            ifid_valid_q <= 1'b0;
            ifid_ir_q    <= NOP_INSTR;
            ifid_pc4_q   <= '0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            resp_pc_q    <= resp_pc_d;
            outst_q      <= outst_d;
            drop_q       <= drop_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_ir_q    <= ifid_ir_d;
            ifid_pc4_q   <= ifid_pc4_d;
        end
    end

    assign ifid_valid = ifid_valid_q;
    assign ifid_ir    = ifid_ir_q;
    assign ifid_pc4   = ifid_pc4_q;

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - directed bench for ifetch_queue with an in-order variable-latency memory
module tb_ifetch_queue;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        ifid_valid;
    logic [31:0] ifid_ir;
    logic [31:0] ifid_pc4;

    int n_checks = 0;
    int n_errors = 0;

    int          cyc = 0;
    int          lat = 1;
    bit          rsp_en = 1'b1;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] acc_log[$];

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clock       (clock),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .ifid_valid  (ifid_valid),
        .ifid_ir     (ifid_ir),
        .ifid_pc4    (ifid_pc4)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: present a response, record an accepted request, advance.
    task automatic tick();
        if (!reset && rsp_en && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend_addr[0] >> 2;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        #1;
        if (imem_req && imem_ack) begin
            pend_addr.push_back(imem_addr);
            pend_due.push_back(cyc + lat);
            acc_log.push_back(imem_addr);
        end
        @(posedge clock);
        if (reset) begin
            pend_addr.delete();
            pend_due.delete();
        end else if (imem_rvalid) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        cyc++;
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        acc_log.delete();
        #1;
    endtask

    initial begin
        int waited;
        int req_before;
        @(negedge clock);

        // Reset and straight-line fetch, L=1
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_eq("rst_valid", ifid_valid, 0);
        check_eq("rst_ir", ifid_ir, 0);
        check_eq("rst_pc4", ifid_pc4, 0);
        check_eq("rst_req", imem_req, 1);
        check_eq("rst_addr", imem_addr, 0);
        tick();
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            check_eq($sformatf("line_valid%0d", i), ifid_valid, 1);
            check_eq($sformatf("line_ir%0d", i), ifid_ir, i);
            check_eq($sformatf("line_pc4_%0d", i), ifid_pc4, 4 * (i + 1));
            check_eq($sformatf("line_addr%0d", i), imem_addr, 4 * (i + 3));
            tick();
        end

        // Reset mid-stream
        reset = 1'b1;
        #1;
        check_eq("mid_rst_req", imem_req, 0);
        tick();
        reset = 1'b0;
        acc_log.delete();
        #1;
        check_eq("mid_rst_valid", ifid_valid, 0);
        check_eq("mid_rst_ir", ifid_ir, 0);
        check_eq("mid_rst_req", imem_req, 1);
        check_eq("mid_rst_addr", imem_addr, 0);

        // Credit limit: responses withheld
        rsp_en = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check_eq("credit_count", acc_log.size(), 4);
        for (int i = 0; i < 4; i++) check_eq($sformatf("credit_addr%0d", i), acc_log[i], 4 * i);
        check_eq("credit_req", imem_req, 0);
        check_eq("credit_valid", ifid_valid, 0);

        // Redirect to 0x10 (low bits ignored) discards the four stale words
        redirect = 1'b1;
        redirect_pc = 32'h13;
        #1;
        check_eq("redir_req_low", imem_req, 0);
        tick();
        redirect = 1'b0;
        stall = 1'b1;
        rsp_en = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check_eq("fill_req", imem_req, 0);
        req_before = acc_log.size();
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq($sformatf("stall_valid%0d", i), ifid_valid, 0);
            check_eq($sformatf("stall_ir%0d", i), ifid_ir, 0);
            check_eq($sformatf("stall_pc4_%0d", i), ifid_pc4, 0);
        end
        check_eq("stall_noreq", acc_log.size(), req_before);
        stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq($sformatf("rel_valid%0d", i), ifid_valid, 1);
            check_eq($sformatf("rel_ir%0d", i), ifid_ir, 4 + i);
            check_eq($sformatf("rel_pc4_%0d", i), ifid_pc4, 32'h14 + 4 * i);
        end

        // Redirect with stale in-flight responses, L=3
        lat = 3;
        do_reset();
        redirect = 1'b1;
        redirect_pc = 32'h20;
        tick();
        redirect = 1'b0;
        tick();
        tick();
        tick();
        check_eq("l3_addr_log1", acc_log[0], 32'h20);
        check_eq("l3_addr_log3", acc_log[2], 32'h28);
        redirect = 1'b1;
        redirect_pc = 32'h100;
        #1;
        check_eq("l3_redir_req", imem_req, 0);
        tick();
        redirect = 1'b0;
        waited = 0;
        while (!ifid_valid && waited < 20) begin
            tick();
            waited++;
        end
        check_eq("l3_wait", waited, 5);
        check_eq("l3_ir", ifid_ir, 32'h40);
        check_eq("l3_pc4", ifid_pc4, 32'h104);
        tick();
        check_eq("l3_ir_next", ifid_ir, 32'h41);

        // Redirect ignored while stalled, L=1
        lat = 1;
        do_reset();
        tick();
        tick();
        tick();
        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h200;
        #1;
        check_eq("rs_req", imem_req, 1);
        check_eq("rs_addr", imem_addr, 32'hC);
        tick();
        stall = 1'b0;
        redirect = 1'b0;
        #1;
        check_eq("rs_hold_ir", ifid_ir, 0);
        check_eq("rs_hold_pc4", ifid_pc4, 4);
        check_eq("rs_addr_next", imem_addr, 32'h10);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq($sformatf("rs_ir%0d", i), ifid_ir, i + 1);
            check_eq($sformatf("rs_pc4_%0d", i), ifid_pc4, 4 * (i + 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
